// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Brief    : Host, decoder and instruction-memory signals of the fetch unit,
//             with the fetch unit as master and its environment as slave.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if;
  logic        run;
  logic        stall;
  logic [5:0]  pc_in;
  logic        pc_we;
  logic [5:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] op;
  logic        op_valid;
  logic [5:0]  pc;
  logic        halted;
  logic [15:0] retired;

  // Fetch unit side
  modport master (
    input  run, stall, pc_in, pc_we, imem_data,
    output imem_addr, op, op_valid, pc, halted, retired
  );

  // Host / decoder / memory side
  modport slave (
    output run, stall, pc_in, pc_we, imem_data,
    input  imem_addr, op, op_valid, pc, halted, retired
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Multi-cycle instruction fetch sequencer. Each instruction takes
//             FETCH (address out), LOAD (capture read data) and EXEC (decoder
//             acts, pc advances or branches). A HALT_OP word parks the unit
//             in HALT until reset.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [5:0]  RESET_PC = 6'd0,
  parameter logic [15:0] HALT_OP  = 16'hFFFF
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fetch_unit_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [15:0] c_RETIRED_MAX = 16'hFFFF;

  state_t      r_state;
  logic [5:0]  r_pc;
  logic [15:0] r_op;
  logic [15:0] r_retired;

  // The address bus mirrors pc; the memory returns data one cycle later.
  assign bus.imem_addr = r_pc;
  assign bus.pc        = r_pc;
  assign bus.op        = r_op;
  assign bus.retired   = r_retired;

  // Status flags decode the registered state only, so no input reaches them.
  assign bus.op_valid  = (r_state == S_EXEC);
  assign bus.halted    = (r_state == S_HALT);

  // Sequencer: state, program counter, instruction register, retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_op      <= 16'h0000;
      r_retired <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_op    <= bus.imem_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // A stalled EXEC keeps everything as is; otherwise the instruction
          // retires (the halt word included) and the unit moves on.
          if (!bus.stall) begin
            if (r_retired != c_RETIRED_MAX) r_retired <= r_retired + 16'd1;
            if (r_op == HALT_OP) begin
              r_state <= S_HALT;
            end else begin
              r_pc    <= bus.pc_we ? bus.pc_in : r_pc + 6'd1;
              r_state <= bus.run ? S_FETCH : S_IDLE;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed self-checking bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [15:0] mem [64];

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (6'd0),
    .HALT_OP  (16'hFFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data for an address shows up next cycle.
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered in FETCH; leaves the unit in EXEC of the instruction at exp_pc.
  task automatic do_instr(input logic [5:0] exp_pc, input logic [15:0] exp_op);
    check("fetch_addr", {10'd0, bus.imem_addr}, {10'd0, exp_pc});
    check("fetch_valid", {15'd0, bus.op_valid}, 16'd0);
    tick();
    check("load_valid", {15'd0, bus.op_valid}, 16'd0);
    check("load_pc", {10'd0, bus.pc}, {10'd0, exp_pc});
    tick();
    check("exec_valid", {15'd0, bus.op_valid}, 16'd1);
    check("exec_op", bus.op, exp_op);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'hFFFF;
    bus.imem_data = 16'h0;
    bus.run   = 1'b0;
    bus.stall = 1'b0;
    bus.pc_we = 1'b0;
    bus.pc_in = 6'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_pc", {10'd0, bus.pc}, 16'd0);
    check("rst_op", bus.op, 16'h0000);
    check("rst_valid", {15'd0, bus.op_valid}, 16'd0);
    check("rst_halted", {15'd0, bus.halted}, 16'd0);
    check("rst_retired", bus.retired, 16'd0);
    tick();
    check("idle_hold_pc", {10'd0, bus.pc}, 16'd0);
    check("idle_hold_valid", {15'd0, bus.op_valid}, 16'd0);

    // Three sequential instructions
    bus.run = 1'b1;
    tick();
    do_instr(6'd0, 16'h1000); tick();
    check("seq_pc1", {10'd0, bus.pc}, 16'd1);
    check("seq_ret1", bus.retired, 16'd1);
    do_instr(6'd1, 16'h1001); tick();
    check("seq_pc2", {10'd0, bus.pc}, 16'd2);
    do_instr(6'd2, 16'h1002); tick();
    check("seq_pc3", {10'd0, bus.pc}, 16'd3);
    check("seq_ret3", bus.retired, 16'd3);

    // Branch taken in EXEC
    do_instr(6'd3, 16'h1003);
    bus.pc_we = 1'b1; bus.pc_in = 6'd20;
    tick();
    bus.pc_we = 1'b0;
    check("br_addr", {10'd0, bus.imem_addr}, 16'd20);
    check("br_ret", bus.retired, 16'd4);

    // Branch strobe outside EXEC is ignored, then a real jump to 63
    bus.pc_we = 1'b1; bus.pc_in = 6'd40;
    tick();
    check("br_ign_load", {10'd0, bus.pc}, 16'd20);
    tick();
    check("br_ign_exec", {10'd0, bus.pc}, 16'd20);
    check("br_ign_op", bus.op, 16'h1014);
    bus.pc_in = 6'd63;
    tick();
    bus.pc_we = 1'b0;
    check("br63_pc", {10'd0, bus.pc}, 16'd63);
    check("br63_ret", bus.retired, 16'd5);

    // Wrap 63 -> 0
    do_instr(6'd63, 16'h103F); tick();
    check("wrap_pc", {10'd0, bus.imem_addr}, 16'd0);
    check("wrap_ret", bus.retired, 16'd6);

    // Stall asserted from FETCH: no effect until EXEC, then holds 4 cycles
    bus.stall = 1'b1;
    do_instr(6'd0, 16'h1000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", {15'd0, bus.op_valid}, 16'd1);
      check("stall_pc", {10'd0, bus.pc}, 16'd0);
      check("stall_ret", bus.retired, 16'd6);
      check("stall_op", bus.op, 16'h1000);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_pc", {10'd0, bus.pc}, 16'd1);
    check("unstall_ret", bus.retired, 16'd7);
    check("unstall_valid", {15'd0, bus.op_valid}, 16'd0);

    // run=0 at EXEC completion returns to IDLE with pc advanced
    do_instr(6'd1, 16'h1001);
    bus.run = 1'b0;
    tick();
    tick();
    check("idle_pc", {10'd0, bus.pc}, 16'd2);
    check("idle_valid", {15'd0, bus.op_valid}, 16'd0);
    check("idle_ret", bus.retired, 16'd8);
    bus.run = 1'b1;
    tick();

    // Run into the halt word at pc 5
    do_instr(6'd2, 16'h1002); tick();
    do_instr(6'd3, 16'h1003); tick();
    do_instr(6'd4, 16'h1004); tick();
    do_instr(6'd5, 16'hFFFF);
    bus.pc_we = 1'b1; bus.pc_in = 6'd9;
    tick();
    check("halt_halted", {15'd0, bus.halted}, 16'd1);
    check("halt_valid", {15'd0, bus.op_valid}, 16'd0);
    check("halt_pc", {10'd0, bus.pc}, 16'd5);
    check("halt_ret", bus.retired, 16'd12);
    for (int i = 0; i < 4; i++) begin
      bus.run = ~bus.run;
      bus.stall = ~bus.stall;
      tick();
      check("halt_stay", {15'd0, bus.halted}, 16'd1);
      check("halt_pc_frz", {10'd0, bus.pc}, 16'd5);
      check("halt_op_frz", bus.op, 16'hFFFF);
      check("halt_ret_frz", bus.retired, 16'd12);
    end
    bus.pc_we = 1'b0; bus.stall = 1'b0; bus.run = 1'b1;

    // Reset leaves HALT, outputs held while rst stays high
    rst = 1'b1;
    tick();
    check("hrst_halted", {15'd0, bus.halted}, 16'd0);
    check("hrst_pc", {10'd0, bus.pc}, 16'd0);
    check("hrst_ret", bus.retired, 16'd0);
    check("hrst_op", bus.op, 16'h0000);
    tick();
    check("hrst_hold_pc", {10'd0, bus.pc}, 16'd0);
    check("hrst_hold_valid", {15'd0, bus.op_valid}, 16'd0);
    rst = 1'b0;
    tick();

    // Reset during EXEC beats a pending branch
    do_instr(6'd0, 16'h1000);
    bus.pc_we = 1'b1; bus.pc_in = 6'd9; rst = 1'b1;
    tick();
    rst = 1'b0; bus.pc_we = 1'b0; bus.run = 1'b0;
    check("xrst_pc", {10'd0, bus.pc}, 16'd0);
    check("xrst_ret", bus.retired, 16'd0);
    check("xrst_valid", {15'd0, bus.op_valid}, 16'd0);
    tick();
    check("xrst_idle_pc", {10'd0, bus.pc}, 16'd0);
    check("xrst_idle_valid", {15'd0, bus.op_valid}, 16'd0);
    bus.run = 1'b1;
    tick();
    do_instr(6'd0, 16'h1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
